// File: rtl/alu_issue_if.sv
// ALU issue interface: instruction-in, ALU drive/return and result-out
// bundles for the alu_issue_seq sequencer.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once the sender raises valid, it holds valid and the
// payload steady until that edge. The receiver may raise or lower ready
// freely. The ALU return (alu_result/alu_bcond) is combinational from the
// ALU drive in the same cycle and has no handshake.
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [3:0]      alu_op;
  logic [1:0]      alu_btype;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic [XLEN-1:0] alu_result;
  logic            alu_bcond;
  logic            out_valid;
  logic            out_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] pc_next;
  logic            illegal;

  // Sequencer side.
  modport master (
    input  inst_valid, inst, inst_pc, rs1_data, rs2_data,
    input  alu_result, alu_bcond, out_ready,
    output inst_ready, alu_op, alu_btype, alu_in_1, alu_in_2,
    output out_valid, wb_en, wb_rd, wb_data, pc_next, illegal
  );

  // Environment side: instruction source, ALU and result consumer.
  modport slave (
    output inst_valid, inst, inst_pc, rs1_data, rs2_data,
    output alu_result, alu_bcond, out_ready,
    input  inst_ready, alu_op, alu_btype, alu_in_1, alu_in_2,
    input  out_valid, wb_en, wb_rd, wb_data, pc_next, illegal
  );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: multi-cycle RV32I issue sequencer driving a shared
// combinational ALU. ALU ops take one ALU cycle. Branches take a SUB compare,
// followed by an ADD target cycle when the branch is taken.
// Optional feature macro: ALU_ISSUE_PERF_EN (adds perf_ops/perf_taken/perf_illegal).
module alu_issue_seq #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_issue_if.master bus,
  output logic [2:0] state_dbg_o
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_ops,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_illegal
`endif
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_ZERO = 4'b1111;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_B  = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_BR_CMP = 3'd2,
    S_BR_TGT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched operation, captured at accept
  logic [3:0]      op_q;
  logic [1:0]      btype_q;
  logic [XLEN-1:0] a_q, b_q, pc_q, bimm_q;

  // Result registers, held through DONE
  logic            wb_en_q, illegal_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q, pc_next_q;

  // ALU drive
  logic [3:0]      alu_op_d;
  logic [1:0]      alu_btype_d;
  logic [XLEN-1:0] alu_a_d, alu_b_d;

  // Instruction fields and immediates of the offered instruction
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_b, shamt_i, shamt_r, pc_inc;
  logic            unused_rs1_field;

  assign opcode  = bus.inst[6:0];
  assign rd      = bus.inst[11:7];
  assign funct3  = bus.inst[14:12];
  assign funct7  = bus.inst[31:25];
  assign imm_i   = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
  assign imm_b   = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                    bus.inst[30:25], bus.inst[11:8], 1'b0};
  assign shamt_i = {{(XLEN-5){1'b0}}, bus.inst[24:20]};
  assign shamt_r = {{(XLEN-5){1'b0}}, bus.rs2_data[4:0]};
  assign pc_inc  = bus.inst_pc + XLEN'(PC_INC);
  // Register indices arrive already resolved into rs1_data/rs2_data.
  assign unused_rs1_field = ^bus.inst[19:15];

  // Decoded view of the offered instruction
  logic            dec_legal, dec_branch;
  logic [3:0]      dec_op;
  logic [1:0]      dec_btype;
  logic [XLEN-1:0] dec_b;

  // Decode: pick ALU op, operand B and branch type; anything unlisted is illegal
  always_comb begin
    dec_legal  = 1'b0;
    dec_branch = 1'b0;
    dec_op     = OP_ZERO;
    dec_btype  = 2'b00;
    dec_b      = bus.rs2_data;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_ADD; end
            else if (funct7 == F7_ALT) begin dec_legal = 1'b1; dec_op = OP_SUB; end
          end
          3'b001: if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_SLL; dec_b = shamt_r; end
          3'b101: begin
            if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_SRL; dec_b = shamt_r; end
            else if (funct7 == F7_ALT) begin dec_legal = 1'b1; dec_op = OP_SRA; dec_b = shamt_r; end
          end
          3'b100: if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_XOR; end
          3'b110: if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_OR; end
          3'b111: if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_AND; end
          default: ;
        endcase
      end
      OPC_I: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_op = OP_OR; end
          3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
          3'b001: if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_SLL; dec_b = shamt_i; end
          3'b101: begin
            if (funct7 == F7_BASE) begin dec_legal = 1'b1; dec_op = OP_SRL; dec_b = shamt_i; end
            else if (funct7 == F7_ALT) begin dec_legal = 1'b1; dec_op = OP_SRA; dec_b = shamt_i; end
          end
          default: ;
        endcase
      end
      OPC_B: begin
        dec_op = OP_SUB;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_branch = 1'b1; dec_btype = 2'b00; end
          3'b001: begin dec_legal = 1'b1; dec_branch = 1'b1; dec_btype = 2'b01; end
          3'b100: begin dec_legal = 1'b1; dec_branch = 1'b1; dec_btype = 2'b10; end
          3'b101: begin dec_legal = 1'b1; dec_branch = 1'b1; dec_btype = 2'b11; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and ALU drive; the ALU sees the ZERO idle op outside ALU cycles
  always_comb begin
    state_d     = state_q;
    alu_op_d    = OP_ZERO;
    alu_btype_d = 2'b00;
    alu_a_d     = '0;
    alu_b_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.inst_valid) begin
          if (!dec_legal)     state_d = S_DONE;
          else if (dec_branch) state_d = S_BR_CMP;
          else                state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op_d = op_q;
        alu_a_d  = a_q;
        alu_b_d  = b_q;
        state_d  = S_DONE;
      end
      S_BR_CMP: begin
        alu_op_d    = OP_SUB;
        alu_btype_d = btype_q;
        alu_a_d     = a_q;
        alu_b_d     = b_q;
        state_d     = bus.alu_bcond ? S_BR_TGT : S_DONE;
      end
      S_BR_TGT: begin
        alu_op_d = OP_ADD;
        alu_a_d  = pc_q;
        alu_b_d  = bimm_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch at accept, result capture from the ALU
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q      <= '0;
      btype_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pc_q      <= '0;
      bimm_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      pc_next_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.inst_valid) begin
            op_q      <= dec_op;
            btype_q   <= dec_btype;
            a_q       <= bus.rs1_data;
            b_q       <= dec_b;
            pc_q      <= bus.inst_pc;
            bimm_q    <= imm_b;
            wb_en_q   <= dec_legal && !dec_branch && (rd != 5'd0);
            wb_rd_q   <= rd;
            wb_data_q <= '0;
            illegal_q <= !dec_legal;
            // Fall-through PC; a taken branch overwrites it in BR_TGT.
            pc_next_q <= pc_inc;
          end
        end
        S_EXEC:   wb_data_q <= bus.alu_result;
        S_BR_TGT: pc_next_q <= bus.alu_result;
        default: ;
      endcase
    end
  end

  assign bus.inst_ready = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.alu_op     = alu_op_d;
  assign bus.alu_btype  = alu_btype_d;
  assign bus.alu_in_1   = alu_a_d;
  assign bus.alu_in_2   = alu_b_d;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.pc_next    = pc_next_q;
  assign bus.illegal    = illegal_q;
  assign state_dbg_o    = state_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [CNT_W-1:0] perf_ops_q, perf_taken_q, perf_illegal_q;

  // Performance counters: ALU cycles, taken branches, illegal accepts
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_ops_q     <= '0;
      perf_taken_q   <= '0;
      perf_illegal_q <= '0;
    end else begin
      if (state_q == S_EXEC || state_q == S_BR_CMP || state_q == S_BR_TGT)
        perf_ops_q <= perf_ops_q + CNT_W'(1);
      if (state_q == S_BR_CMP && bus.alu_bcond)
        perf_taken_q <= perf_taken_q + CNT_W'(1);
      if (state_q == S_IDLE && bus.inst_valid && !dec_legal)
        perf_illegal_q <= perf_illegal_q + CNT_W'(1);
    end
  end

  assign perf_ops     = perf_ops_q;
  assign perf_taken   = perf_taken_q;
  assign perf_illegal = perf_illegal_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq: acts as instruction source, combinational ALU
// and result consumer; checks against an instruction-level reference model.
module tb_alu_issue_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus ();
  logic [2:0] dbg_state_unused;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops, perf_taken, perf_illegal;
  logic [31:0] exp_ops = 0, exp_taken = 0, exp_illegal = 0;
`endif

  alu_issue_seq #(.XLEN(32), .PC_INC(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .state_dbg_o (dbg_state_unused)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops     (perf_ops),
    .perf_taken   (perf_taken),
    .perf_illegal (perf_illegal)
`endif
  );

  // Combinational ALU model answering the sequencer's drive
  logic [31:0] alu_r;
  always_comb begin
    case (bus.alu_op)
      4'b0000: alu_r = bus.alu_in_1 + bus.alu_in_2;
      4'b0001: alu_r = bus.alu_in_1 - bus.alu_in_2;
      4'b1010: alu_r = bus.alu_in_1 << bus.alu_in_2[4:0];
      4'b1011: alu_r = bus.alu_in_1 >> bus.alu_in_2[4:0];
      4'b1101: alu_r = $unsigned($signed(bus.alu_in_1) >>> bus.alu_in_2[4:0]);
      4'b0100: alu_r = bus.alu_in_1 & bus.alu_in_2;
      4'b0101: alu_r = bus.alu_in_1 | bus.alu_in_2;
      4'b1000: alu_r = bus.alu_in_1 ^ bus.alu_in_2;
      default: alu_r = 32'h0;
    endcase
    bus.alu_result = alu_r;
    case (bus.alu_btype)
      2'b00:   bus.alu_bcond = (alu_r == 32'h0);
      2'b01:   bus.alu_bcond = (alu_r != 32'h0);
      2'b10:   bus.alu_bcond = alu_r[31];
      default: bus.alu_bcond = !alu_r[31];
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected behaviour of one instruction
  typedef struct {
    bit          legal;
    bit          br;
    bit          taken;
    bit          wb_en;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] pc_next;
    int          lat;
    logic [3:0]  op;
    logic [1:0]  bt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] immb;
  } m_t;

  function automatic m_t model(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2);
    m_t m;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] immi, shi, shr, diff;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    immi = {{20{ins[31]}}, ins[31:20]};
    shi  = {27'd0, ins[24:20]};
    shr  = {27'd0, r2[4:0]};
    m.legal = 0; m.br = 0; m.taken = 0; m.rd = ins[11:7];
    m.res = 0; m.op = 4'hF; m.bt = 2'b00; m.a = r1; m.b = r2;
    m.immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    m.pc_next = pc + 32'd4;
    if (opc == 7'h33) begin
      if (f3 == 0 && f7 == 0)          begin m.legal = 1; m.op = 4'b0000; m.res = r1 + r2; end
      else if (f3 == 0 && f7 == 7'h20) begin m.legal = 1; m.op = 4'b0001; m.res = r1 - r2; end
      else if (f3 == 1 && f7 == 0)     begin m.legal = 1; m.op = 4'b1010; m.b = shr; m.res = r1 << r2[4:0]; end
      else if (f3 == 5 && f7 == 0)     begin m.legal = 1; m.op = 4'b1011; m.b = shr; m.res = r1 >> r2[4:0]; end
      else if (f3 == 5 && f7 == 7'h20) begin m.legal = 1; m.op = 4'b1101; m.b = shr; m.res = $unsigned($signed(r1) >>> r2[4:0]); end
      else if (f3 == 4 && f7 == 0)     begin m.legal = 1; m.op = 4'b1000; m.res = r1 ^ r2; end
      else if (f3 == 6 && f7 == 0)     begin m.legal = 1; m.op = 4'b0101; m.res = r1 | r2; end
      else if (f3 == 7 && f7 == 0)     begin m.legal = 1; m.op = 4'b0100; m.res = r1 & r2; end
    end else if (opc == 7'h13) begin
      m.b = immi;
      if (f3 == 0)                     begin m.legal = 1; m.op = 4'b0000; m.res = r1 + immi; end
      else if (f3 == 4)                begin m.legal = 1; m.op = 4'b1000; m.res = r1 ^ immi; end
      else if (f3 == 6)                begin m.legal = 1; m.op = 4'b0101; m.res = r1 | immi; end
      else if (f3 == 7)                begin m.legal = 1; m.op = 4'b0100; m.res = r1 & immi; end
      else if (f3 == 1 && f7 == 0)     begin m.legal = 1; m.op = 4'b1010; m.b = shi; m.res = r1 << shi[4:0]; end
      else if (f3 == 5 && f7 == 0)     begin m.legal = 1; m.op = 4'b1011; m.b = shi; m.res = r1 >> shi[4:0]; end
      else if (f3 == 5 && f7 == 7'h20) begin m.legal = 1; m.op = 4'b1101; m.b = shi; m.res = $unsigned($signed(r1) >>> shi[4:0]); end
    end else if (opc == 7'h63) begin
      diff = r1 - r2;
      m.op = 4'b0001;
      case (f3)
        3'd0: begin m.legal = 1; m.bt = 2'b00; m.taken = (r1 == r2); end
        3'd1: begin m.legal = 1; m.bt = 2'b01; m.taken = (r1 != r2); end
        3'd4: begin m.legal = 1; m.bt = 2'b10; m.taken = diff[31]; end
        3'd5: begin m.legal = 1; m.bt = 2'b11; m.taken = !diff[31]; end
        default: ;
      endcase
      m.br = m.legal;
      if (m.taken) m.pc_next = pc + m.immb;
    end
    m.wb_en = m.legal && !m.br && (m.rd != 5'd0);
    m.lat   = !m.legal ? 1 : (m.taken ? 3 : 2);
    return m;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Offer one instruction, follow it to DONE, hold out_ready low for hold
  // cycles, then retire it. With junk set, inst_valid stays high with random
  // payload while the sequencer is busy.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input int hold, input bit junk);
    m_t m;
    int w, lat;
    logic [31:0] s_pc, s_data;
    m = model(ins, pc, r1, r2);
    bus.inst_valid = 1'b1;
    bus.inst       = ins;
    bus.inst_pc    = pc;
    bus.rs1_data   = r1;
    bus.rs2_data   = r2;
    w = 0;
    while (bus.inst_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("ready_timeout", 32'(w < 20), 32'd1);
    @(negedge clk);
    lat = 1;
    if (junk) begin
      bus.inst     = $urandom;
      bus.inst_pc  = $urandom;
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
    end else begin
      bus.inst_valid = 1'b0;
    end
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      chk("busy_inst_ready", bus.inst_ready, 0);
      if (lat == 1) begin
        chk("c1_alu_op", bus.alu_op, m.op);
        chk("c1_alu_in_1", bus.alu_in_1, m.a);
        chk("c1_alu_in_2", bus.alu_in_2, m.b);
        if (m.br) chk("c1_btype", bus.alu_btype, m.bt);
      end
      if (lat == 2 && m.taken) begin
        chk("c2_alu_op", bus.alu_op, 4'b0000);
        chk("c2_alu_in_1", bus.alu_in_1, pc);
        chk("c2_alu_in_2", bus.alu_in_2, m.immb);
      end
      @(negedge clk);
      lat++;
    end
    bus.inst_valid = 1'b0;
    chk("latency", lat, m.lat);
    chk("illegal", bus.illegal, m.legal ? 0 : 1);
    chk("wb_en", bus.wb_en, m.wb_en);
    chk("pc_next", bus.pc_next, m.pc_next);
    if (m.legal && !m.br) begin
      chk("wb_rd", bus.wb_rd, m.rd);
      chk("wb_data", bus.wb_data, m.res);
    end
    chk("done_alu_op", bus.alu_op, 4'hF);
    s_pc   = bus.pc_next;
    s_data = bus.wb_data;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_inst_ready", bus.inst_ready, 0);
      chk("hold_pc_next", bus.pc_next, s_pc);
      chk("hold_wb_data", bus.wb_data, s_data);
      chk("hold_illegal", bus.illegal, m.legal ? 0 : 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ret_out_valid", bus.out_valid, 0);
    chk("ret_inst_ready", bus.inst_ready, 1);
`ifdef ALU_ISSUE_PERF_EN
    exp_ops     = exp_ops + (!m.legal ? 0 : (m.taken ? 2 : 1));
    exp_taken   = exp_taken + (m.taken ? 1 : 0);
    exp_illegal = exp_illegal + (m.legal ? 0 : 1);
    chk("perf_ops", perf_ops, exp_ops);
    chk("perf_taken", perf_taken, exp_taken);
    chk("perf_illegal", perf_illegal, exp_illegal);
`endif
  endtask

  logic [31:0] ins, r1, r2, pc;
  logic [6:0]  f7;
  logic [11:0] imm12;
  logic [12:0] imm13;
  int k;

  initial begin
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.inst_pc    = '0;
    bus.rs1_data   = '0;
    bus.rs2_data   = '0;
    bus.out_ready  = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_inst_ready", bus.inst_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_pc_next", bus.pc_next, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_alu_op", bus.alu_op, 4'hF);
    chk("rst_alu_btype", bus.alu_btype, 0);
    chk("rst_alu_in_1", bus.alu_in_1, 0);
    chk("rst_alu_in_2", bus.alu_in_2, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0000_1000, 32'd5, 32'd7, 0, 0);
    chk("add_wb_data_12", bus.wb_data, 32'd12);
    issue(enc_i(12'h404, 5'd1, 3'd5, 5'd5), 32'h0000_2000, 32'hF000_0000, 32'd0, 1, 0);
    chk("srai_wb_data", bus.wb_data, 32'hFF00_0000);
    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h0000_0100, 32'd9, 32'd9, 0, 0);
    chk("beq_pc_next", bus.pc_next, 32'h0000_00F8);
    issue(enc_b(13'h0010, 5'd2, 5'd1, 3'd4), 32'h0000_0200, 32'd3, 32'd1, 0, 0);
    issue(enc_b(13'h0010, 5'd2, 5'd1, 3'd5), 32'h0000_0200, 32'd3, 32'd1, 0, 0);
    issue(32'h0000_007F, 32'h0000_0300, 32'd1, 32'd2, 5, 1);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h0000_0400, 32'd1, 32'd2, 0, 0);
    issue(enc_i(12'h001, 5'd1, 3'd0, 5'd7), 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd0, 0, 0);
    issue(enc_r(7'h01, 5'd2, 5'd1, 3'd1, 5'd4), 32'h0000_0500, 32'd1, 32'd2, 0, 0);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd4), 32'h0000_0600, 32'd1, 32'hFFFF_FFE3, 2, 1);

    // Reset while the branch target is being computed
    bus.inst_valid = 1'b1;
    bus.inst       = enc_b(13'h0020, 5'd2, 5'd1, 3'd0);
    bus.inst_pc    = 32'h0000_0700;
    bus.rs1_data   = 32'd4;
    bus.rs2_data   = 32'd4;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    @(negedge clk);
    chk("tgt_alu_op", bus.alu_op, 4'b0000);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_inst_ready", bus.inst_ready, 1);
    chk("midrst_alu_op", bus.alu_op, 4'hF);
`ifdef ALU_ISSUE_PERF_EN
    exp_ops = 0; exp_taken = 0; exp_illegal = 0;
    chk("midrst_perf_ops", perf_ops, 0);
    chk("midrst_perf_taken", perf_taken, 0);
    chk("midrst_perf_illegal", perf_illegal, 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 9);
      r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      pc = {$urandom, 2'b00} ;
      case ($urandom_range(0, 3))
        0, 2:    f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      if (k <= 3) begin
        ins = enc_r(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
      end else if (k <= 6) begin
        imm12 = 12'($urandom);
        ins = enc_i(imm12, 5'($urandom), 3'($urandom), 5'($urandom));
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ins[31:25] = f7;
      end else if (k <= 8) begin
        imm13 = {12'($urandom), 1'b0};
        if ($urandom_range(0, 2) == 0) r2 = r1;
        ins = enc_b(imm13, 5'($urandom), 5'($urandom), 3'($urandom));
      end else begin
        ins = $urandom;
      end
      issue(ins, pc, r1, r2, $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
